answer_judge: RTL and testbench

- Consumes the symbol stream from the symbol generator and the phase pulses from the clock-blip stage.
- Counts special symbols during the game period.
- At the end of the answer period, compares that count against the user's up/down count.
- Produces game_count, count_diff (score), level_up, lives and loss, which feed the level controller and the 7-seg display stage.

---
 rtl/game_pkg.sv | 17 +
 rtl/answer_judge_sat_counter.sv | 25 ++
 rtl/answer_judge.sv | 164 ++++++++++++++++
 tb/tb_answer_judge.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the game datapath: the phase enum that the judge
// FSM walks through and the default widths/limits for a round.
package game_pkg;

    // Round phases. LOST is terminal until reset.
    typedef enum logic [2:0] {
        IDLE,
        COUNT,
        ANSWER,
        JUDGE,
        LOST
    } phase_t;

    localparam int CNT_W_DEF     = 7;
    localparam int MAX_LIVES_DEF = 3;

endpackage

// File: rtl/answer_judge_sat_counter.sv
// Saturating up-counter with synchronous clear and count enable.
// Clear has priority over enable, so a pulse that arrives together with
// clear is dropped. The count sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         en,
    output logic [W-1:0] count
);

    // Count register: clear wins, then increment unless already full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/answer_judge.sv
// answer_judge: counts special symbols during the game phase, then compares
// that count against the user's tally when the answer phase ends, updating
// score, lives and the loss flag.
//
// Optional build macro ANSWER_JUDGE_STREAK_BONUS_EN adds a 2-bit streak
// counter (and a streak port); three correct answers in a row grant a life,
// capped at MAX_LIVES.
//
// Handshake/pulse contract: game_begin, game_end, answer_end and sym_valid
// are single-cycle strobes sampled on the rising clock edge; a strobe that
// does not belong to the current phase is ignored. judge_valid and level_up
// are single-cycle strobes asserted in the JUDGE cycle, which is the cycle
// after answer_end is sampled; count_diff, correct and lives already carry
// the new result in that cycle and hold it until the next judge.
module answer_judge
    import game_pkg::*;
#(
    parameter int CNT_W     = CNT_W_DEF,
    parameter int MAX_LIVES = MAX_LIVES_DEF,
    parameter int TOL       = 0
) (
    input  logic             Clk100M,
    input  logic             reset,
    input  logic             game_begin,
    input  logic             game_end,
    input  logic             answer_end,
    input  logic             sym_valid,
    input  logic             sym_special,
    input  logic [CNT_W-1:0] user_count,
    output logic [CNT_W-1:0] game_count,
    output logic [CNT_W-1:0] count_diff,
    output logic             judge_valid,
    output logic             correct,
    output logic             level_up,
    output logic [1:0]       lives,
    output logic             loss,
`ifdef ANSWER_JUDGE_STREAK_BONUS_EN
    output logic [1:0]       streak,
`endif
    output phase_t           state
);

    localparam logic [1:0]     MAX_L = MAX_LIVES[1:0];
    localparam logic [CNT_W:0] TOL_V = TOL[CNT_W:0];

    phase_t next_state;
    logic   count_clear;
    logic   count_en;
    logic   judge_fire;

    logic [CNT_W:0]   wide_gc;
    logic [CNT_W:0]   wide_uc;
    logic [CNT_W:0]   wide_diff;
    logic [CNT_W-1:0] diff;
    logic             is_correct;

    sat_counter #(.W(CNT_W)) u_game_count (
        .clk   (Clk100M),
        .rst   (reset),
        .clear (count_clear),
        .en    (count_en),
        .count (game_count)
    );

    // Absolute difference at CNT_W+1 bits; user_count is taken live in the
    // answer_end cycle, which is the only cycle judge_fire can be high.
    always_comb begin
        wide_gc    = {1'b0, game_count};
        wide_uc    = {1'b0, user_count};
        wide_diff  = (wide_gc >= wide_uc) ? (wide_gc - wide_uc) : (wide_uc - wide_gc);
        diff       = wide_diff[CNT_W-1:0];
        is_correct = (wide_diff <= TOL_V);
    end

    // Phase register.
    always_ff @(posedge Clk100M or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-phase and per-phase strobes; stray pulses fall through untouched.
    always_comb begin
        next_state  = state;
        count_clear = 1'b0;
        count_en    = 1'b0;
        judge_fire  = 1'b0;
        case (state)
            IDLE: begin
                if (game_begin) begin
                    count_clear = 1'b1;
                    next_state  = COUNT;
                end
            end
            COUNT: begin
                count_en = sym_valid && sym_special;
                if (game_end) begin
                    next_state = ANSWER;
                end
            end
            ANSWER: begin
                if (answer_end) begin
                    judge_fire = 1'b1;
                    next_state = JUDGE;
                end
            end
            JUDGE: begin
                // loss was registered on entry to JUDGE together with lives.
                next_state = loss ? LOST : IDLE;
            end
            LOST: begin
                next_state = LOST;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Judge results: registered on answer_end so they are visible in JUDGE.
    always_ff @(posedge Clk100M or posedge reset) begin
        if (reset) begin
            count_diff  <= '0;
            correct     <= 1'b0;
            judge_valid <= 1'b0;
            level_up    <= 1'b0;
            lives       <= MAX_L;
            loss        <= 1'b0;
`ifdef ANSWER_JUDGE_STREAK_BONUS_EN
            streak      <= 2'd0;
`endif
        end else begin
            judge_valid <= judge_fire;
            level_up    <= judge_fire && is_correct;
            if (judge_fire) begin
                count_diff <= diff;
                correct    <= is_correct;
                if (is_correct) begin
`ifdef ANSWER_JUDGE_STREAK_BONUS_EN
                    if (streak == 2'd2) begin
                        streak <= 2'd0;
                        if (lives < MAX_L) begin
                            lives <= lives + 2'd1;
                        end
                    end else begin
                        streak <= streak + 2'd1;
                    end
`endif
                end else begin
                    lives <= lives - 2'd1;
                    if (lives == 2'd1) begin
                        loss <= 1'b1;
                    end
`ifdef ANSWER_JUDGE_STREAK_BONUS_EN
                    streak <= 2'd0;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_answer_judge.sv
// Self-checking bench for answer_judge. Rounds are played by driver tasks;
// expected results come from the game rules (saturating symbol count,
// absolute difference, lives/loss bookkeeping) kept in plain integers.
// Also builds with ANSWER_JUDGE_STREAK_BONUS_EN defined.
module tb_answer_judge;
    import game_pkg::*;

    localparam int CNT_W     = 7;
    localparam int MAX_LIVES = 3;
    localparam int TOL       = 0;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    logic             clk;
    logic             reset;
    logic             game_begin;
    logic             game_end;
    logic             answer_end;
    logic             sym_valid;
    logic             sym_special;
    logic [CNT_W-1:0] user_count;
    logic [CNT_W-1:0] game_count;
    logic [CNT_W-1:0] count_diff;
    logic             judge_valid;
    logic             correct;
    logic             level_up;
    logic [1:0]       lives;
    logic             loss;
    phase_t           state;
`ifdef ANSWER_JUDGE_STREAK_BONUS_EN
    logic [1:0]       streak;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model of the game outcome.
    int m_lives;
    int m_streak;
    bit m_loss;
    int m_diff;
    bit m_correct;

    answer_judge #(.CNT_W(CNT_W), .MAX_LIVES(MAX_LIVES), .TOL(TOL)) dut (
        .Clk100M     (clk),
        .reset       (reset),
        .game_begin  (game_begin),
        .game_end    (game_end),
        .answer_end  (answer_end),
        .sym_valid   (sym_valid),
        .sym_special (sym_special),
        .user_count  (user_count),
        .game_count  (game_count),
        .count_diff  (count_diff),
        .judge_valid (judge_valid),
        .correct     (correct),
        .level_up    (level_up),
        .lives       (lives),
        .loss        (loss),
`ifdef ANSWER_JUDGE_STREAK_BONUS_EN
        .streak      (streak),
`endif
        .state       (state)
    );

    // Clock / reset block.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        game_begin  = 1'b0;
        game_end    = 1'b0;
        answer_end  = 1'b0;
        sym_valid   = 1'b0;
        sym_special = 1'b0;
        user_count  = '0;
        step();
        step();
        reset = 1'b0;
        step();
        m_lives  = MAX_LIVES;
        m_streak = 0;
        m_loss   = 1'b0;
        m_diff   = 0;
        m_correct = 1'b0;
    endtask

    // Driver: one symbol pulse.
    task automatic send_sym(input bit special);
        sym_valid   = 1'b1;
        sym_special = special;
        step();
        sym_valid   = 1'b0;
        sym_special = 1'b0;
    endtask

    // Driver: game_begin then a shuffled mix of special/plain symbols.
    task automatic start_and_count(input int n_sp, input int n_pl);
        int sp;
        int pl;
        sp = n_sp;
        pl = n_pl;
        game_begin = 1'b1;
        step();
        game_begin = 1'b0;
        while (sp + pl > 0) begin
            if (sp > 0 && (pl == 0 || $urandom_range(0, 1) == 1)) begin
                send_sym(1'b1);
                sp--;
            end else begin
                send_sym(1'b0);
                pl--;
            end
            if ($urandom_range(0, 3) == 0) step();
        end
    endtask

    // Driver + checks: answer_end with the given user tally, then judge.
    task automatic judge_and_check(input int exp_cnt, input int user, input string tag);
        m_diff    = (exp_cnt > user) ? exp_cnt - user : user - exp_cnt;
        m_correct = (m_diff <= TOL);
        if (m_correct) begin
`ifdef ANSWER_JUDGE_STREAK_BONUS_EN
            m_streak++;
            if (m_streak == 3) begin
                m_streak = 0;
                if (m_lives < MAX_LIVES) m_lives++;
            end
`endif
        end else begin
            m_lives--;
            m_streak = 0;
            if (m_lives == 0) m_loss = 1'b1;
        end
        user_count = CNT_W'(user);
        answer_end = 1'b1;
        step();
        answer_end = 1'b0;
        user_count = CNT_W'($urandom_range(0, CNT_MAX));
        checks++; if (judge_valid !== 1'b1) begin errors++; $display("FAIL %s judge_valid got %0d exp 1", tag, judge_valid); end
        checks++; if (level_up !== m_correct) begin errors++; $display("FAIL %s level_up got %0d exp %0d", tag, level_up, m_correct); end
        checks++; if (count_diff !== CNT_W'(m_diff)) begin errors++; $display("FAIL %s count_diff got %0d exp %0d", tag, count_diff, m_diff); end
        checks++; if (correct !== m_correct) begin errors++; $display("FAIL %s correct got %0d exp %0d", tag, correct, m_correct); end
        checks++; if (lives !== 2'(m_lives)) begin errors++; $display("FAIL %s lives got %0d exp %0d", tag, lives, m_lives); end
        checks++; if (loss !== m_loss) begin errors++; $display("FAIL %s loss got %0d exp %0d", tag, loss, m_loss); end
`ifdef ANSWER_JUDGE_STREAK_BONUS_EN
        checks++; if (streak !== 2'(m_streak)) begin errors++; $display("FAIL %s streak got %0d exp %0d", tag, streak, m_streak); end
`endif
        step();
        checks++; if (judge_valid !== 1'b0 || level_up !== 1'b0) begin errors++; $display("FAIL %s pulse_width jv=%0d lu=%0d exp 0 0", tag, judge_valid, level_up); end
        checks++; if (count_diff !== CNT_W'(m_diff) || correct !== m_correct) begin errors++; $display("FAIL %s hold diff=%0d corr=%0d exp %0d %0d", tag, count_diff, correct, m_diff, m_correct); end
        checks++; if (state !== (m_loss ? LOST : IDLE)) begin errors++; $display("FAIL %s post_state got %s exp %s", tag, state.name(), m_loss ? "LOST" : "IDLE"); end
    endtask

    // Full round: count, end game, check tally, judge.
    task automatic play_round(input int n_sp, input int n_pl, input int user, input string tag);
        int exp_cnt;
        exp_cnt = (n_sp > CNT_MAX) ? CNT_MAX : n_sp;
        start_and_count(n_sp, n_pl);
        game_end = 1'b1;
        step();
        game_end = 1'b0;
        checks++; if (game_count !== CNT_W'(exp_cnt)) begin errors++; $display("FAIL %s game_count got %0d exp %0d", tag, game_count, exp_cnt); end
        if ($urandom_range(0, 1) == 1) step();
        judge_and_check(exp_cnt, user, tag);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (game_count !== '0 || count_diff !== '0) begin errors++; $display("FAIL reset counts gc=%0d diff=%0d exp 0 0", game_count, count_diff); end
        checks++; if (judge_valid !== 1'b0 || correct !== 1'b0 || level_up !== 1'b0) begin errors++; $display("FAIL reset flags jv=%0d c=%0d lu=%0d exp 0", judge_valid, correct, level_up); end
        checks++; if (lives !== 2'(MAX_LIVES) || loss !== 1'b0) begin errors++; $display("FAIL reset lives=%0d loss=%0d exp %0d 0", lives, loss, MAX_LIVES); end
        checks++; if (state !== IDLE) begin errors++; $display("FAIL reset state got %s exp IDLE", state.name()); end
    endtask

    task automatic test_correct();
        do_reset();
        play_round(5, 3, 5, "correct_5");
    endtask

    task automatic test_random();
        int n_sp;
        int user;
        do_reset();
        for (int r = 0; r < 6; r++) begin
            n_sp = $urandom_range(0, 20);
            if (m_lives > 1 && $urandom_range(0, 1) == 1) user = n_sp + $urandom_range(1, 3);
            else user = n_sp;
            play_round(n_sp, $urandom_range(0, 10), user, "random");
        end
    endtask

    task automatic test_loss();
        do_reset();
        for (int r = 0; r < 3; r++) play_round(4, 2, 7, "loss_round");
        // Terminal: phase pulses and symbols are ignored.
        game_begin = 1'b1; sym_valid = 1'b1; sym_special = 1'b1;
        step();
        game_begin = 1'b0; sym_valid = 1'b0; sym_special = 1'b0;
        game_end = 1'b1; step(); game_end = 1'b0;
        answer_end = 1'b1; step(); answer_end = 1'b0;
        checks++; if (state !== LOST) begin errors++; $display("FAIL lost_sticky state got %s exp LOST", state.name()); end
        checks++; if (game_count !== CNT_W'(4)) begin errors++; $display("FAIL lost_count got %0d exp 4", game_count); end
        checks++; if (judge_valid !== 1'b0 || level_up !== 1'b0 || loss !== 1'b1 || lives !== 2'd0) begin errors++; $display("FAIL lost_outputs jv=%0d lu=%0d loss=%0d lives=%0d exp 0 0 1 0", judge_valid, level_up, loss, lives); end
    endtask

    task automatic test_saturation();
        do_reset();
        play_round(130, 0, 0, "saturate");
    endtask

    task automatic test_boundary();
        do_reset();
        // Symbol coincident with game_begin is not counted.
        game_begin = 1'b1; sym_valid = 1'b1; sym_special = 1'b1;
        step();
        game_begin = 1'b0; sym_valid = 1'b0; sym_special = 1'b0;
        checks++; if (game_count !== '0 || state !== COUNT) begin errors++; $display("FAIL begin_sym gc=%0d state=%s exp 0 COUNT", game_count, state.name()); end
        send_sym(1'b1);
        send_sym(1'b1);
        // Stray answer_end during COUNT.
        answer_end = 1'b1; step(); answer_end = 1'b0;
        checks++; if (judge_valid !== 1'b0 || state !== COUNT) begin errors++; $display("FAIL stray_answer jv=%0d state=%s exp 0 COUNT", judge_valid, state.name()); end
        step();
        checks++; if (judge_valid !== 1'b0) begin errors++; $display("FAIL stray_answer_late jv=%0d exp 0", judge_valid); end
        // Symbol coincident with game_end is counted.
        game_end = 1'b1; sym_valid = 1'b1; sym_special = 1'b1;
        step();
        game_end = 1'b0; sym_valid = 1'b0; sym_special = 1'b0;
        checks++; if (game_count !== CNT_W'(3) || state !== ANSWER) begin errors++; $display("FAIL end_sym gc=%0d state=%s exp 3 ANSWER", game_count, state.name()); end
        // Stray game_begin and symbols during ANSWER.
        game_begin = 1'b1; sym_valid = 1'b1; sym_special = 1'b1;
        step();
        game_begin = 1'b0; sym_valid = 1'b0; sym_special = 1'b0;
        checks++; if (game_count !== CNT_W'(3) || state !== ANSWER) begin errors++; $display("FAIL stray_begin gc=%0d state=%s exp 3 ANSWER", game_count, state.name()); end
        judge_and_check(3, 3, "boundary_judge");
    endtask

    task automatic test_async_reset();
        do_reset();
        play_round(4, 0, 7, "pre_reset");
        play_round(4, 0, 7, "pre_reset");
        start_and_count(9, 2);
        checks++; if (game_count !== CNT_W'(9) || lives !== 2'd1) begin errors++; $display("FAIL mid_count gc=%0d lives=%0d exp 9 1", game_count, lives); end
        #3;
        reset = 1'b1;
        #1;
        checks++; if (game_count !== '0 || lives !== 2'(MAX_LIVES) || loss !== 1'b0) begin errors++; $display("FAIL async_reset gc=%0d lives=%0d loss=%0d exp 0 %0d 0", game_count, lives, loss, MAX_LIVES); end
        checks++; if (state !== IDLE || judge_valid !== 1'b0 || level_up !== 1'b0) begin errors++; $display("FAIL async_reset_state state=%s jv=%0d lu=%0d exp IDLE 0 0", state.name(), judge_valid, level_up); end
        step();
        reset = 1'b0;
        step();
        m_lives = MAX_LIVES; m_streak = 0; m_loss = 1'b0;
        play_round(2, 1, 2, "post_reset");
    endtask

`ifdef ANSWER_JUDGE_STREAK_BONUS_EN
    task automatic test_streak();
        do_reset();
        play_round(3, 1, 5, "streak_wrong");
        for (int r = 0; r < 3; r++) play_round(r + 1, 2, r + 1, "streak_right");
        checks++; if (lives !== 2'd3 || streak !== 2'd0) begin errors++; $display("FAIL streak_grant lives=%0d streak=%0d exp 3 0", lives, streak); end
    endtask
`endif

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_correct();
        test_random();
        test_loss();
        test_saturation();
        test_boundary();
        test_async_reset();
`ifdef ANSWER_JUDGE_STREAK_BONUS_EN
        test_streak();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
